daq_readout: RTL

- Host-side reader for the DAQ event stream: consumes the TDC result (16-bit count plus one-cycle data_valid strobe) and forwards it off-chip.
- Each accepted event is tagged with an 8-bit sequence number and buffered in a small FIFO.
- Events are sent as fixed 4-byte UART 8N1 frames, so the PC can rebuild muon-decay time histograms and detect lost events.
- Sits directly after the daq block, in the same clock domain.

---
 rtl/daq_readout_pkg.sv | 25 ++
 rtl/daq_readout_uart.sv | 87 ++++++++
 rtl/daq_readout.sv | 128 ++++++++++++
 3 files changed

// File: rtl/daq_readout_pkg.sv
// Shared definitions for the DAQ readout path: FIFO entry width, frame
// layout, the default sync byte and the state types of both FSMs.
package daq_readout_pkg;

    localparam int         ENTRY_W           = 24;     // {seq[7:0], tdc[15:0]}
    localparam int         FRAME_BYTES       = 4;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic {IDLE, SEND} rd_state_t;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Byte idx of an event frame: sync, seq, tdc[15:8], tdc[7:0].
    function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                              input logic [1:0]         idx,
                                              input logic [7:0]         sync);
        case (idx)
            2'd0:    frame_byte = sync;
            2'd1:    frame_byte = entry[23:16];
            2'd2:    frame_byte = entry[15:8];
            default: frame_byte = entry[7:0];
        endcase
    endfunction

endpackage

// File: rtl/daq_readout_uart.sv
// uart_tx_byte: 8N1 serializer for one byte.
// Ports: clk, rst (sync, active high), data/start (byte request),
//        tx (serial line, idles high), ready (start will be accepted),
//        done (one-cycle pulse in the last cycle of the stop bit).
// ready is also high in the done cycle so the next byte can follow the
// stop bit with no idle gap.
module uart_tx_byte
    import daq_readout_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       ready,
    output logic       done
);

    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n, last;

    assign last  = (cnt == LAST_C);
    assign done  = (state == TX_STOP) && last;
    assign ready = (state == TX_IDLE) || done;

    always_comb begin
        nxt       = state;
        cnt_n     = (state == TX_IDLE || last) ? '0 : cnt + CW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        case (state)
            TX_IDLE: if (start) begin
                nxt     = TX_START;
                shreg_n = data;
            end
            TX_START: if (last) begin
                nxt       = TX_DATA;
                bit_idx_n = '0;
            end
            TX_DATA: if (last) begin
                shreg_n   = {1'b0, shreg[7:1]};
                bit_idx_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) nxt = TX_STOP;
            end
            TX_STOP: if (last) begin
                if (start) begin
                    nxt     = TX_START;
                    shreg_n = data;
                end else begin
                    nxt = TX_IDLE;
                end
            end
            default: nxt = TX_IDLE;
        endcase
        // tx is registered from the next state so the line is glitch-free
        case (nxt)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = shreg_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= nxt;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end
    end

endmodule

// File: rtl/daq_readout.sv
// daq_readout: tags each TDC event with an 8-bit sequence number, buffers
// it in a small FIFO and sends it as a 4-byte UART frame
// (SYNC_BYTE, seq, tdc[15:8], tdc[7:0]).
// Ports: clk, rst (sync, active high), tdc_in/data_valid (event input),
//        tx (UART line), busy (frame in flight or FIFO non-empty),
//        fifo_count (buffered events), drop (pulse per discarded event),
//        overflow_cnt (saturating drop count).
module daq_readout
    import daq_readout_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   tdc_in,
    input  logic                          data_valid,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          drop,
    output logic [7:0]                    overflow_cnt
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [7:0]         seq;
    logic               full, push, pop;

    rd_state_t          state, nxt;
    logic [1:0]         byte_idx;
    logic [ENTRY_W-1:0] hold;
    logic               tx_start, tx_ready, tx_done;
    logic [7:0]         tx_data;

    // Fullness comes from the registered count: a pop in this cycle does
    // not make room for this cycle's push.
    assign full = (fifo_count == DEPTH_C);
    assign push = data_valid && !full;
    assign busy = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= {seq, tdc_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            seq          <= '0;
            drop         <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            drop <= data_valid && full;
            if (data_valid && full && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The sync byte is a constant, so it is handed to the serializer in the
    // pop cycle itself; later bytes come from the holding register, which
    // keeps the frame in flight independent of further FIFO writes.
    always_comb begin
        nxt      = state;
        pop      = 1'b0;
        tx_start = 1'b0;
        tx_data  = frame_byte(hold, 2'd0, SYNC_BYTE);
        case (state)
            IDLE: if (fifo_count != '0 && tx_ready) begin
                pop      = 1'b1;
                tx_start = 1'b1;
                nxt      = SEND;
            end
            SEND: if (tx_done) begin
                if (byte_idx == 2'(FRAME_BYTES - 1)) begin
                    nxt = IDLE;
                end else begin
                    tx_start = 1'b1;
                    tx_data  = frame_byte(hold, byte_idx + 2'd1, SYNC_BYTE);
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_idx <= '0;
            hold     <= '0;
        end else begin
            state <= nxt;
            if (pop) begin
                hold     <= mem[rd_ptr];
                byte_idx <= '0;
            end else if (state == SEND && tx_done &&
                         byte_idx != 2'(FRAME_BYTES - 1)) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (tx_data),
        .start (tx_start),
        .tx    (tx),
        .ready (tx_ready),
        .done  (tx_done)
    );

endmodule
